// File: rtl/f2h_arb_pkg.sv
// rtl/f2h_arb_pkg.sv - shared types for the f2h_sdram read arbiter
//
// Purpose: requester id type, outstanding-burst FIFO entry and requester
// id constants, shared by arb_id_fifo and f2h_sdram_rd_arbiter.
// No ports.

package f2h_arb_pkg;

  // Width of the burst field stored per outstanding burst. It must match
  // the BURST_W parameter of f2h_sdram_rd_arbiter.
  localparam int ENTRY_BURST_W = 8;

  typedef logic req_id_t;

  localparam req_id_t REQ_M0 = 1'b0;
  localparam req_id_t REQ_M1 = 1'b1;

  typedef struct packed {
    req_id_t                  id;
    logic [ENTRY_BURST_W-1:0] burst;
  } fifo_entry_t;

endpackage : f2h_arb_pkg

// File: rtl/arb_id_fifo.sv
// rtl/arb_id_fifo.sv - synchronous FIFO of outstanding burst ids
//
// Purpose: remembers which requester issued each accepted burst and its
// length, oldest first, so returning beats can be routed.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push       write push_data (ignored when full)
//   push_data  entry to queue
//   pop        drop the head entry (ignored when empty)
//   head       oldest entry (valid when !empty)
//   full       count == DEPTH
//   empty      count == 0
//   count      number of queued entries

module arb_id_fifo
  import f2h_arb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  fifo_entry_t       push_data,
  input  logic              pop,
  output fifo_entry_t       head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  fifo_entry_t             mem_q [DEPTH];
  fifo_entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    do_push;
  logic                    do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Push and pop together leave the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : arb_id_fifo

// File: rtl/f2h_sdram_rd_arbiter.sv
// rtl/f2h_sdram_rd_arbiter.sv - two-requester arbiter for the f2h_sdram read port
//
// Purpose: round-robin command arbitration between requester m0 (frame
// reader) and m1 (secondary client) onto one Avalon-MM read port, with
// the grant locked while the port stalls, and routing of returned beats
// to the requester that issued each burst.
// Optional build macro: F2H_ARB_STATS_EN adds saturating counters
// stat_grants0, stat_grants1 and stat_stall.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   m0_* / m1_*                 requester Avalon-MM read slaves
//                               (address, burstcount, read, waitrequest,
//                               readdata, readdatavalid)
//   sdram_*                     Avalon-MM read master to f2h_sdram
//   stat_grants0/1, stat_stall  (F2H_ARB_STATS_EN only) accept counts per
//                               requester, cycles with a request but no accept

module f2h_sdram_rd_arbiter
  import f2h_arb_pkg::*;
#(
  parameter int ADDR_W          = 29,
  parameter int DATA_W          = 64,
  parameter int BURST_W         = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk,
  input  logic               rst,

  input  logic [ADDR_W-1:0]  m0_address,
  input  logic [BURST_W-1:0] m0_burstcount,
  input  logic               m0_read,
  output logic               m0_waitrequest,
  output logic [DATA_W-1:0]  m0_readdata,
  output logic               m0_readdatavalid,

  input  logic [ADDR_W-1:0]  m1_address,
  input  logic [BURST_W-1:0] m1_burstcount,
  input  logic               m1_read,
  output logic               m1_waitrequest,
  output logic [DATA_W-1:0]  m1_readdata,
  output logic               m1_readdatavalid,

  output logic [ADDR_W-1:0]  sdram_address,
  output logic [BURST_W-1:0] sdram_burstcount,
  output logic               sdram_read,
  input  logic               sdram_waitrequest,
  input  logic [DATA_W-1:0]  sdram_readdata,
  input  logic               sdram_readdatavalid
`ifdef F2H_ARB_STATS_EN
  ,
  output logic [31:0]        stat_grants0,
  output logic [31:0]        stat_grants1,
  output logic [31:0]        stat_stall
`endif
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  req_id_t            prio_q, prio_d;
  req_id_t            grant_q, grant_d;
  logic               locked_q, locked_d;
  logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;

  req_id_t            sel;
  logic               sel_read;
  logic               issue;
  logic               accept;
  logic               stall_hold;
  logic               sel_wait;
  logic               resp_hit;
  logic               last_beat;

  fifo_entry_t        push_entry;
  fifo_entry_t        head;
  logic               fifo_full;
  logic               fifo_full_flag;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  // ---------------------------------------------------------------------
  // Command arbitration (combinational, zero-cycle request to command)
  // ---------------------------------------------------------------------
  always_comb begin
    sel = REQ_M0;
    if (locked_q) begin
      // A stalled command must be held unchanged until accepted.
      sel = grant_q;
    end else if (m0_read && m1_read) begin
      sel = prio_q;
    end else if (m1_read) begin
      sel = REQ_M1;
    end
  end

  assign fifo_full  = (fifo_count == CNT_W'(MAX_OUTSTANDING));
  assign sel_read   = (sel == REQ_M1) ? m1_read : m0_read;
  // No bypass when full: a pop in the same cycle does not free a slot early.
  assign issue      = sel_read && !fifo_full && !rst;
  assign accept     = issue && !sdram_waitrequest;
  assign stall_hold = issue && sdram_waitrequest;
  assign sel_wait   = sdram_waitrequest || fifo_full;

  assign sdram_read       = issue;
  assign sdram_address    = (sel == REQ_M1) ? m1_address    : m0_address;
  assign sdram_burstcount = (sel == REQ_M1) ? m1_burstcount : m0_burstcount;

  assign m0_waitrequest = rst || (sel != REQ_M0) || sel_wait;
  assign m1_waitrequest = rst || (sel != REQ_M1) || sel_wait;

  always_comb begin
    prio_d   = prio_q;
    grant_d  = grant_q;
    locked_d = locked_q;
    if (accept) begin
      prio_d   = ~sel;
      locked_d = 1'b0;
    end else if (stall_hold) begin
      locked_d = 1'b1;
      grant_d  = sel;
    end
  end

  // ---------------------------------------------------------------------
  // Outstanding-burst tracking and response routing
  // ---------------------------------------------------------------------
  assign push_entry.id    = sel;
  assign push_entry.burst = sdram_burstcount;

  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept && !fifo_full_flag),
    .push_data (push_entry),
    .pop       (last_beat),
    .head      (head),
    .full      (fifo_full_flag),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Beats arriving with nothing outstanding (e.g. tail of a burst issued
  // before a reset) are dropped.
  assign resp_hit  = sdram_readdatavalid && !fifo_empty && !rst;
  assign last_beat = resp_hit && ((beat_cnt_q + BURST_W'(1)) == head.burst);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (last_beat) begin
      beat_cnt_d = '0;
    end else if (resp_hit) begin
      beat_cnt_d = beat_cnt_q + BURST_W'(1);
    end
  end

  assign m0_readdatavalid = resp_hit && (head.id == REQ_M0);
  assign m1_readdatavalid = resp_hit && (head.id == REQ_M1);
  assign m0_readdata      = sdram_readdata;
  assign m1_readdata      = sdram_readdata;

`ifdef F2H_ARB_STATS_EN
  // ---------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------
  logic [31:0] stat_grants0_q, stat_grants0_d;
  logic [31:0] stat_grants1_q, stat_grants1_d;
  logic [31:0] stat_stall_q,   stat_stall_d;

  always_comb begin
    stat_grants0_d = stat_grants0_q;
    stat_grants1_d = stat_grants1_q;
    stat_stall_d   = stat_stall_q;
    if (accept && (sel == REQ_M0) && (stat_grants0_q != 32'hFFFF_FFFF)) begin
      stat_grants0_d = stat_grants0_q + 32'd1;
    end
    if (accept && (sel == REQ_M1) && (stat_grants1_q != 32'hFFFF_FFFF)) begin
      stat_grants1_d = stat_grants1_q + 32'd1;
    end
    if ((m0_read || m1_read) && !accept && (stat_stall_q != 32'hFFFF_FFFF)) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grants0_q <= '0;
      stat_grants1_q <= '0;
      stat_stall_q   <= '0;
    end else begin
      stat_grants0_q <= stat_grants0_d;
      stat_grants1_q <= stat_grants1_d;
      stat_stall_q   <= stat_stall_d;
    end
  end

  assign stat_grants0 = stat_grants0_q;
  assign stat_grants1 = stat_grants1_q;
  assign stat_stall   = stat_stall_q;
`endif

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q     <= REQ_M0;
      grant_q    <= REQ_M0;
      locked_q   <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      prio_q     <= prio_d;
      grant_q    <= grant_d;
      locked_q   <= locked_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule : f2h_sdram_rd_arbiter

// File: doc/f2h_sdram_rd_arbiter.md
Name: f2h_sdram_rd_arbiter

Overview:
Two-requester arbiter for the single FPGA-to-HPS SDRAM Avalon-MM read port. The frame reader (m0) and a secondary read client (m1, e.g. a DMA or overlay fetch) share the port. The block does round-robin command arbitration with grant lock during waitrequest. It tracks outstanding bursts in an ID FIFO and routes each readdatavalid beat back to the requester that issued the burst.

Parameters:
ADDR_W, 29, address width of the f2h_sdram port
DATA_W, 64, readdata width
BURST_W, 8, burstcount width
MAX_OUTSTANDING, 4, maximum accepted-but-incomplete bursts (ID FIFO depth, power of 2)

Ports:
clk  in  1  sdram-side clock
rst  in  1  asynchronous active-high reset
m0_address  in  ADDR_W  requester 0 burst address
m0_burstcount  in  BURST_W  requester 0 beats (1..2^BURST_W-1)
m0_read  in  1  requester 0 read command
m0_waitrequest  out  1  requester 0 stall
m0_readdata  out  DATA_W  broadcast from sdram_readdata
m0_readdatavalid  out  1  beat belongs to requester 0
m1_address, m1_burstcount, m1_read, m1_waitrequest, m1_readdata, m1_readdatavalid: same as m0 for requester 1
sdram_address  out  ADDR_W  to f2h_sdram
sdram_burstcount  out  BURST_W  to f2h_sdram
sdram_read  out  1  to f2h_sdram
sdram_waitrequest  in  1  from f2h_sdram
sdram_readdata  in  DATA_W  from f2h_sdram
sdram_readdatavalid  in  1  from f2h_sdram

Behaviour:
- Reset values: sdram_read=0, m0/m1_waitrequest=1, m*_readdatavalid=0, priority=m0, locked=0, FIFO empty, beat_cnt=0. While rst is high, outputs are forced to these values combinationally.
- Arbitration is combinational, with zero cycles from m*_read to sdram_read. If unlocked, select the requesting master. If both request, select the one holding priority.
- Selected master's address/burstcount are muxed to sdram_*. sdram_read = selected read && !fifo_full.
- Accept condition: sdram_read && !sdram_waitrequest. On accept: push {id, burstcount} into the FIFO, clear locked, and set priority to the other requester.
- If sdram_read && sdram_waitrequest: set locked and hold the grant until accept. Avalon requires the master to hold its command, so the grant never switches mid-stall.
- Non-selected master: waitrequest=1. Selected master: waitrequest = sdram_waitrequest || fifo_full.
- fifo_full (count==MAX_OUTSTANDING): no command is issued and both requesters see waitrequest=1. There is no same-cycle bypass, even if a pop occurs that cycle.
- Response routing: on sdram_readdatavalid with FIFO non-empty, assert m[head_id]_readdatavalid and increment beat_cnt. When beat_cnt+1 == head_burstcount, pop the head and clear beat_cnt.
- m*_readdata carries sdram_readdata unregistered, so response latency is zero.
- readdatavalid with FIFO empty (stray beat, e.g. after reset mid-burst): dropped, no requester valid.
- Simultaneous push and pop: count unchanged. The new entry is correctly queued behind the head.
- Reset mid-operation: all outstanding state is discarded. No recovery of in-flight beats.
- burstcount=0 is a protocol violation. Behaviour is undefined and the bench must not drive it.

Optional Feature:
Macro F2H_ARB_STATS_EN.
- Defined: adds outputs stat_grants0, stat_grants1 and stat_stall (32 bits each, reset 0, saturating).
  - stat_grants0/1 count accepts per requester.
  - stat_stall counts cycles where any m*_read is high and no accept occurs.
- Undefined: these ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Package f2h_arb_pkg:
  - req_id_t (1-bit requester id)
  - fifo_entry_t struct {req_id_t id; logic [BURST_W-1:0] burst;}
  - localparams REQ_M0=0, REQ_M1=1
- Sub-module arb_id_fifo: synchronous FIFO of fifo_entry_t. It provides push, pop, head, full, empty and count, with async active-high reset.

Test Plan:
- Single master: m0 reads addr 0x100, burst 4, downstream waitrequest=0 → sdram_read for 1 cycle; 4 valid beats all go to m0_readdatavalid; FIFO empties after the 4th beat.
- Contention: m0 and m1 both request every cycle with burst 2 → accepts alternate m0, m1, m0, m1; returned data routed in the same order (beats 0-1 to m0, 2-3 to m1).
- Lock: m1 is granted and sdram_waitrequest is held high 5 cycles while m0 also requests → sdram_address stays at m1's address for all 5 cycles; m0_waitrequest=1; m0 is granted on the next cycle after accept.
- Full: 4 bursts of 8 accepted with no data returned, then a 5th request → waitrequest=1 and sdram_read=0 until the first burst's 8th beat pops; the 5th request is accepted the following cycle.
- Reset mid-burst: rst asserted after 2 of 4 beats, then 2 more readdatavalid beats → both m*_readdatavalid stay 0; waitrequest=1 during reset; normal operation after release.
- With F2H_ARB_STATS_EN: contention run of 10 accepts → stat_grants0=5, stat_grants1=5; stat_stall equals the number of cycles with a pending request and no accept.
